// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and
// the bit-counter width helper.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    CCFF_IDLE = 2'd0,
    CCFF_LOAD = 2'd1,
    CCFF_DONE = 2'd2
  } ccff_state_e;

  // Counter must represent 0..chain_len inclusive.
  function automatic int ccff_cnt_w(input int chain_len);
    return (chain_len < 1) ? 1 : $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that turns a valid/ready word stream into LSB-first serial
// bits; refills on the last bit so the chain can advance every cycle.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              shift,
  input  logic              flush,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              head,
  output logic              rem_nz
);

  localparam int REM_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [REM_W-1:0]  rem_q, rem_d;

  assign rem_nz = (rem_q != '0);
  assign head   = word_q[0];
  // A flush cycle never accepts: the word would be discarded on the same edge.
  assign s_ready = active && !flush &&
                   ((rem_q == '0) || ((rem_q == REM_W'(1)) && shift));

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    if (flush) begin
      word_d = '0;
      rem_d  = '0;
    end else if (s_valid && s_ready) begin
      word_d = s_data;
      rem_d  = REM_W'(WORD_W);
    end else if (shift) begin
      word_d = word_q >> 1;
      rem_d  = rem_q - REM_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      rem_q  <= '0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader: FSM, bit counter, tail-integrity
// check and status flags around the word serializer.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = ccff_cnt_w(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  input  logic              tail_check_en,
  output logic              busy,
  output logic              done,
  output logic              err_tail,
  output logic [CNT_W-1:0]  bit_count
);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             err_tail_q, err_tail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic rem_nz;
  logic shift;
  logic last_shift;
  logic enter_load;
  logic flush;

  assign shift      = (state_q == CCFF_LOAD) && rem_nz;
  assign last_shift = shift && (bit_count_q == CNT_W'(CHAIN_LEN - 1));
  assign enter_load = start && !abort && (state_q != CCFF_LOAD);
  // Leftover bits of the final word are dropped on the completing edge.
  assign flush      = abort || enter_load || last_shift;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk     (prog_clk),
    .rst_n   (pReset),
    .active  (state_q == CCFF_LOAD),
    .shift   (shift),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .head    (ccff_head),
    .rem_nz  (rem_nz)
  );

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    err_tail_d  = err_tail_q;
    case (state_q)
      CCFF_IDLE, CCFF_DONE: if (start) state_d = CCFF_LOAD;
      CCFF_LOAD: begin
        if (shift) begin
          bit_count_d = bit_count_q + CNT_W'(1);
          if (tail_check_en && ccff_tail) err_tail_d = 1'b1;
          if (last_shift) state_d = CCFF_DONE;
        end
      end
      default: state_d = CCFF_IDLE;
    endcase
    if (enter_load) begin
      bit_count_d = '0;
      err_tail_d  = 1'b0;
    end
    // Abort wins over everything and freezes the count and error flag.
    if (abort) begin
      state_d     = CCFF_IDLE;
      bit_count_d = bit_count_q;
      err_tail_d  = err_tail_q;
    end
    busy_d = (state_d == CCFF_LOAD);
    done_d = (state_d == CCFF_DONE);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q     <= CCFF_IDLE;
      bit_count_q <= '0;
      err_tail_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      err_tail_q  <= err_tail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ccff_shift_en = shift;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_tail      = err_tail_q;
  assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a 20-bit chain and 8-bit words.
module tb_ccff_loader;
  import ccff_loader_pkg::*;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = ccff_cnt_w(CHAIN_LEN);
  localparam logic [19:0] EXP_HEADS = 20'hF3CA5;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              tail_check_en;
  logic              busy;
  logic              done;
  logic              err_tail;
  logic [CNT_W-1:0]  bit_count;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] words [3] = '{8'hA5, 8'h3C, 8'hFF};

  typedef struct {
    string name;
    int    gap;
    int    tail_shift;
    bit    tail_en;
    int    start_mid;
    int    exp_shifts;
    int    exp_run;
    int    exp_stall;
    int    exp_err_shift;
  } vec_t;

  typedef struct {
    int          shifts;
    int          max_run;
    int          stall;
    int          err_shift;
    int          done_cyc;
    int          last_shift;
    logic [31:0] heads;
    bit          ready_late;
  } res_t;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .tail_check_en (tail_check_en),
    .busy          (busy),
    .done          (done),
    .err_tail      (err_tail),
    .bit_count     (bit_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),       32'd0);
    check({tag, "_head"},      32'(ccff_head),     32'd0);
    check({tag, "_shift_en"},  32'(ccff_shift_en), 32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_err_tail"},  32'(err_tail),      32'd0);
    check({tag, "_bit_count"}, 32'(bit_count),     32'd0);
  endtask

  // One full load of A5,3C,FF; stalls s_valid for v.gap refill opportunities
  // after the first word, optionally injects a tail bit or a mid-load start.
  task automatic run_load(input vec_t v, output res_t r);
    int   sc, run, widx, gap_left, first, last;
    logic se, rdy, vld;
    r = '{default: 0};
    r.err_shift = -1;
    r.done_cyc  = -1;
    sc = 0; run = 0; widx = 0; gap_left = 0; first = -1; last = -1;
    @(negedge prog_clk);
    start = 1'b1; s_valid = 1'b0; ccff_tail = 1'b0; tail_check_en = v.tail_en;
    @(negedge prog_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) begin
        r.done_cyc = cyc;
        break;
      end
      if (err_tail && r.err_shift < 0) r.err_shift = sc;
      se        = ccff_shift_en;
      ccff_tail = (v.tail_shift != 0) && se && (sc + 1 == v.tail_shift);
      start     = (v.start_mid != 0) && se && (sc + 1 == v.start_mid);
      #1;
      rdy = s_ready;
      if (widx >= 3) vld = 1'b0;
      else if (gap_left > 0 && rdy) begin
        vld = 1'b0;
        gap_left--;
      end else vld = 1'b1;
      s_valid = vld;
      s_data  = (widx < 3) ? words[widx] : '0;
      #1;
      if (se) begin
        if (sc < 32) r.heads[sc] = ccff_head;
        sc++;
        run++;
        if (run > r.max_run) r.max_run = run;
        if (first < 0) first = cyc;
        last = cyc;
      end else run = 0;
      if (rdy && widx >= 3) r.ready_late = 1'b1;
      if (vld && rdy) begin
        widx++;
        if (widx == 1) gap_left = v.gap;
      end
      @(negedge prog_clk);
    end
    start = 1'b0; ccff_tail = 1'b0; s_valid = 1'b0;
    r.shifts     = sc;
    r.stall      = (first < 0) ? -1 : (last - first + 1 - sc);
    r.last_shift = last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    res_t r;
    int   n;

    vecs[0] = '{"cont",     0, 0, 1'b0, 0, 20, 20, 0, -1};
    vecs[1] = '{"starve",   3, 0, 1'b0, 0, 20, 12, 3, -1};
    vecs[2] = '{"tail_en",  0, 7, 1'b1, 0, 20, 20, 0,  7};
    vecs[3] = '{"tail_dis", 0, 7, 1'b0, 0, 20, 20, 0, -1};
    vecs[4] = '{"start_mid",0, 0, 1'b0, 5, 20, 20, 0, -1};

    pReset = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    s_data = '0; ccff_tail = 1'b0; tail_check_en = 1'b0;
    repeat (2) @(negedge prog_clk);
    #1 check_all_zero("por");
    @(negedge prog_clk);
    pReset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i], r);
      check($sformatf("%s_timeout", vecs[i].name), 32'(r.done_cyc >= 0), 32'd1);
      check($sformatf("%s_shifts", vecs[i].name), r.shifts, vecs[i].exp_shifts);
      check($sformatf("%s_run", vecs[i].name), r.max_run, vecs[i].exp_run);
      check($sformatf("%s_stall", vecs[i].name), r.stall, vecs[i].exp_stall);
      check($sformatf("%s_heads", vecs[i].name), 32'(r.heads[19:0]), 32'(EXP_HEADS));
      check($sformatf("%s_done_lat", vecs[i].name), r.done_cyc - r.last_shift, 32'd1);
      check($sformatf("%s_bit_count", vecs[i].name), 32'(bit_count), CHAIN_LEN);
      check($sformatf("%s_busy_off", vecs[i].name), 32'({busy, ccff_shift_en, s_ready}), 32'd0);
      check($sformatf("%s_ready_late", vecs[i].name), 32'(r.ready_late), 32'd0);
      check($sformatf("%s_err_shift", vecs[i].name), r.err_shift, vecs[i].exp_err_shift);
      check($sformatf("%s_err_tail", vecs[i].name), 32'(err_tail), 32'(vecs[i].exp_err_shift >= 0));
    end

    // Reset mid-load at bit_count 5, then start is required again.
    @(negedge prog_clk);
    start = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    @(negedge prog_clk);
    start = 1'b0;
    n = 0;
    while (bit_count != 5 && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check("rst_reach_bc5", 32'(bit_count), 32'd5);
    pReset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge prog_clk);
    pReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      check($sformatf("rst_idle_%0d", i), 32'({s_ready, busy, ccff_shift_en}), 32'd0);
    end

    // Abort at bit_count 9 with a tail error pending, then restart.
    tail_check_en = 1'b1; ccff_tail = 1'b1;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    #1 check("restart_ready", 32'({s_ready, busy}), 32'b11);
    n = 0;
    while (bit_count != 9 && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check("abort_reach_bc9", 32'(bit_count), 32'd9);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0; ccff_tail = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd0);
    check("abort_shift_en", 32'(ccff_shift_en), 32'd0);
    check("abort_bit_count", 32'(bit_count), 32'd9);
    check("abort_err_held", 32'(err_tail), 32'd1);
    @(negedge prog_clk);
    check("abort_bc_hold", 32'(bit_count), 32'd9);
    tail_check_en = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    #1;
    check("restart_bc_clr", 32'(bit_count), 32'd0);
    check("restart_err_clr", 32'(err_tail), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge prog_clk);
      n++;
    end
    check("restart_done", 32'({done, bit_count}), 32'({1'b1, 5'd20}));

    // Abort in DONE clears done but keeps the count; start+abort stays IDLE.
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    #1 check("abort_done", 32'({done, busy, bit_count}), 32'({2'b00, 5'd20}));
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    #1 check("start_abort", 32'({busy, s_ready, done}), 32'd0);
    s_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
